// File: rtl/ctrl_fsm_hs_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_fsm_hs_pkg
// Shared definitions for the accumulator-machine control unit: FSM state
// encoding, the sixteen opcodes, accumulator/PC source-select encodings, the
// latched-flag and execute-strobe bundles, and a helper that classifies ALU
// opcodes.
// -----------------------------------------------------------------------------
package ctrl_fsm_hs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALT    = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

   // Opcodes (upper 4 bits of the instruction word)
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDR  = 4'h2;
   localparam logic [3:0] OP_STR  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JMPR = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JN   = 4'hD;
   localparam logic [3:0] OP_JC   = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Accumulator source select
   localparam logic [1:0] SEL_ACC_IMM = 2'b00;
   localparam logic [1:0] SEL_ACC_REG = 2'b01;
   localparam logic [1:0] SEL_ACC_ALU = 2'b10;

   // PC source select
   localparam logic SEL_PC_REG = 1'b0;
   localparam logic SEL_PC_IMM = 1'b1;

   // ALU flags as latched at the end of an ALU EXECUTE cycle
   typedef struct packed {
      logic z;
      logic n;
      logic c;
   } flags_t;

   // Everything the EXECUTE cycle drives towards the datapath
   typedef struct packed {
      logic       load_pc;
      logic       load_acc;
      logic       load_reg;
      logic       sel_pc;
      logic [1:0] sel_acc;
      logic [3:0] alu_op;
   } exec_ctrl_t;

   // Opcodes 4..9 are ALU operations (plain unsigned range test)
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_CMP);
   endfunction

endpackage : ctrl_fsm_hs_pkg

// File: rtl/ctrl_fsm_hs_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode decoder. Maps the opcode and the latched ALU
// flags to the strobe/select bundle that applies during an EXECUTE cycle.
// The caller is responsible for gating the result with the FSM state.
//
// Ports
//   opcode   in  4  instruction opcode
//   flag_z   in  1  latched zero flag
//   flag_n   in  1  latched negative flag
//   flag_c   in  1  latched carry flag
//   load_pc  out 1  load program counter
//   load_acc out 1  load accumulator
//   load_reg out 1  write register file
//   sel_pc   out 1  PC source (1 = immediate, 0 = register file)
//   sel_acc  out 2  accumulator source (00 imm, 01 reg, 1x ALU)
//   alu_op   out 4  ALU operation code
// -----------------------------------------------------------------------------
module ctrl_decode
   import ctrl_fsm_hs_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       flag_z,
   input  logic       flag_n,
   input  logic       flag_c,
   output logic       load_pc,
   output logic       load_acc,
   output logic       load_reg,
   output logic       sel_pc,
   output logic [1:0] sel_acc,
   output logic [3:0] alu_op
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      load_pc  = 1'b0;
      load_acc = 1'b0;
      load_reg = 1'b0;
      sel_pc   = SEL_PC_REG;
      sel_acc  = SEL_ACC_IMM;
      alu_op   = 4'h0;

      if (is_alu_op(opcode)) begin
         load_acc = 1'b1;
         sel_acc  = SEL_ACC_ALU;
         alu_op   = opcode;
      end else begin
         case (opcode)
            OP_LDI: begin
               load_acc = 1'b1;
               sel_acc  = SEL_ACC_IMM;
            end
            OP_LDR: begin
               load_acc = 1'b1;
               sel_acc  = SEL_ACC_REG;
            end
            OP_STR: begin
               load_reg = 1'b1;
            end
            OP_JMP: begin
               load_pc = 1'b1;
               sel_pc  = SEL_PC_IMM;
            end
            OP_JMPR: begin
               load_pc = 1'b1;
               sel_pc  = SEL_PC_REG;
            end
            OP_JZ: begin
               load_pc = flag_z;
               sel_pc  = flag_z ? SEL_PC_IMM : SEL_PC_REG;
            end
            OP_JN: begin
               load_pc = flag_n;
               sel_pc  = flag_n ? SEL_PC_IMM : SEL_PC_REG;
            end
            OP_JC: begin
               load_pc = flag_c;
               sel_pc  = flag_c ? SEL_PC_IMM : SEL_PC_REG;
            end
            // NOP, HLT: no strobes
            default: ;
         endcase
      end
   end

endmodule : ctrl_decode

// File: rtl/ctrl_fsm_hs.sv
// -----------------------------------------------------------------------------
// ctrl_fsm_hs
// Control unit for a small accumulator machine. Sequences
// IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ..., with a bounded wait for the
// instruction memory handshake (FAULT on expiry) and a sticky HALT.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       level; leaves IDLE when high
//   instr     in   4+IMMW  instruction register {opcode, immediate}
//   imem_ack  in   1       instruction memory data valid
//   flagZ/N/C in   1       live ALU flags
//   imem_req  out  1       fetch request (high in FETCH)
//   loadIR    out  1       load IR (FETCH and imem_ack)
//   incPC     out  1       increment PC (FETCH and imem_ack)
//   loadPC    out  1       load PC
//   loadAcc   out  1       load accumulator
//   loadReg   out  1       write register file
//   selPC     out  1       1 = immediate, 0 = register file
//   selACC    out  2       00 imm, 01 register file, 1x ALU
//   aluOp     out  4       ALU operation code
//   halt      out  1       sticky, high in HALT
//   fault     out  1       sticky, high in FAULT (fetch timeout)
//
// The Moore outputs are registered from the next state, so they line up with
// the state they belong to. The EXECUTE bundle is therefore decoded during
// DECODE, when the IR already holds the new instruction and the flag latch
// still holds the result of the last ALU operation.
// -----------------------------------------------------------------------------
module ctrl_fsm_hs
   import ctrl_fsm_hs_pkg::*;
#(
   parameter int IMMW    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IMMW+3:0] instr,
   input  logic            imem_ack,
   input  logic            flagZ,
   input  logic            flagN,
   input  logic            flagC,
   output logic            imem_req,
   output logic            loadIR,
   output logic            incPC,
   output logic            loadPC,
   output logic            loadAcc,
   output logic            loadReg,
   output logic            selPC,
   output logic [1:0]      selACC,
   output logic [3:0]      aluOp,
   output logic            halt,
   output logic            fault
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   flags_t           flags_q,    flags_d;
   exec_ctrl_t       exec_q,     exec_d;
   logic             imem_req_q, imem_req_d;
   logic             halt_q,     halt_d;
   logic             fault_q,    fault_d;

   exec_ctrl_t       dec_ctrl;
   logic [3:0]       opcode;

   assign opcode = instr[IMMW+3:IMMW];

   // The immediate itself goes straight to the datapath; only the opcode
   // matters to the controller.
   logic unused_imm_bits;
   assign unused_imm_bits = ^instr[IMMW-1:0];

   ctrl_decode u_decode (
      .opcode   (opcode),
      .flag_z   (flags_q.z),
      .flag_n   (flags_q.n),
      .flag_c   (flags_q.c),
      .load_pc  (dec_ctrl.load_pc),
      .load_acc (dec_ctrl.load_acc),
      .load_reg (dec_ctrl.load_reg),
      .sel_pc   (dec_ctrl.sel_pc),
      .sel_acc  (dec_ctrl.sel_acc),
      .alu_op   (dec_ctrl.alu_op)
   );

   // -------------------------------------------------------------------------
   // Next-state, wait counter, flag latch and registered-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      flags_d    = flags_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // An ack on the last permitted cycle still wins over the timeout.
            if (imem_ack) begin
               state_d = ST_DECODE;
            end else if (wait_cnt_q == CNT_LAST) begin
               state_d = ST_FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (is_alu_op(opcode)) begin
               flags_d = '{z: flagZ, n: flagN, c: flagC};
            end
            state_d = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
         end
         ST_HALT:  state_d = ST_HALT;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase

      // Every FETCH starts with a fresh wait budget.
      if (state_d == ST_FETCH && state_q != ST_FETCH) begin
         wait_cnt_d = '0;
      end

      imem_req_d = (state_d == ST_FETCH);
      halt_d     = (state_d == ST_HALT);
      fault_d    = (state_d == ST_FAULT);
      exec_d     = (state_d == ST_EXECUTE) ? dec_ctrl : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         flags_q    <= '0;
         exec_q     <= '0;
         imem_req_q <= 1'b0;
         halt_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         flags_q    <= flags_d;
         exec_q     <= exec_d;
         imem_req_q <= imem_req_d;
         halt_q     <= halt_d;
         fault_q    <= fault_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // IR load and PC increment must coincide with the data-valid cycle, so
   // they are the only outputs qualified combinationally by imem_ack.
   assign loadIR   = (state_q == ST_FETCH) && imem_ack;
   assign incPC    = (state_q == ST_FETCH) && imem_ack;

   assign imem_req = imem_req_q;
   assign loadPC   = exec_q.load_pc;
   assign loadAcc  = exec_q.load_acc;
   assign loadReg  = exec_q.load_reg;
   assign selPC    = exec_q.sel_pc;
   assign selACC   = exec_q.sel_acc;
   assign aluOp    = exec_q.alu_op;
   assign halt     = halt_q;
   assign fault    = fault_q;

endmodule : ctrl_fsm_hs

// File: tb/tb_ctrl_fsm_hs.sv
// -----------------------------------------------------------------------------
// tb_ctrl_fsm_hs
// Self-checking bench for ctrl_fsm_hs. A behavioural model tracks the latched
// flags and derives the expected output vector for each instruction phase
// straight from the instruction-set table. Inputs change just after the
// falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_ctrl_fsm_hs;

   localparam int IMMW    = 4;
   localparam int TIMEOUT = 16;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            start    = 1'b0;
   logic [IMMW+3:0] instr    = '0;
   logic            imem_ack = 1'b0;
   logic            flagZ    = 1'b0;
   logic            flagN    = 1'b0;
   logic            flagC    = 1'b0;

   logic       imem_req, loadIR, incPC, loadPC, loadAcc, loadReg, selPC;
   logic [1:0] selACC;
   logic [3:0] aluOp;
   logic       halt, fault;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: latched flags as the architecture defines them
   logic mz = 1'b0, mn = 1'b0, mc = 1'b0;

   ctrl_fsm_hs #(.IMMW(IMMW), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .instr    (instr),
      .imem_ack (imem_ack),
      .flagZ    (flagZ),
      .flagN    (flagN),
      .flagC    (flagC),
      .imem_req (imem_req),
      .loadIR   (loadIR),
      .incPC    (incPC),
      .loadPC   (loadPC),
      .loadAcc  (loadAcc),
      .loadReg  (loadReg),
      .selPC    (selPC),
      .selACC   (selACC),
      .aluOp    (aluOp),
      .halt     (halt),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   logic [14:0] obs;
   assign obs = {imem_req, loadIR, incPC, loadPC, loadAcc, loadReg,
                 selPC, selACC, aluOp, halt, fault};

   function automatic logic [14:0] vec(input logic req, input logic lir,
                                       input logic ipc, input logic lpc,
                                       input logic lacc, input logic lreg,
                                       input logic spc, input logic [1:0] sacc,
                                       input logic [3:0] alu, input logic hlt,
                                       input logic flt);
      return {req, lir, ipc, lpc, lacc, lreg, spc, sacc, alu, hlt, flt};
   endfunction

   localparam logic [14:0] V_ZERO  = '0;
   localparam logic [14:0] V_HALT  = 15'b000000000000010;
   localparam logic [14:0] V_FAULT = 15'b000000000000001;
   localparam logic [14:0] V_REQ   = 15'b100000000000000;

   // Expected EXECUTE-cycle outputs, straight from the instruction table
   function automatic logic [14:0] exp_exec(input logic [3:0] op);
      int          k;
      logic [2:0]  fl;
      k  = int'(op);
      fl = {mz, mn, mc};
      if (k == 1)             return vec(0,0,0,0,1,0,0,2'b00,4'h0,0,0);
      if (k == 2)             return vec(0,0,0,0,1,0,0,2'b01,4'h0,0,0);
      if (k == 3)             return vec(0,0,0,0,0,1,0,2'b00,4'h0,0,0);
      if (k >= 4 && k <= 9)   return vec(0,0,0,0,1,0,0,2'b10,op,0,0);
      if (k == 10)            return vec(0,0,0,1,0,0,1,2'b00,4'h0,0,0);
      if (k == 11)            return vec(0,0,0,1,0,0,0,2'b00,4'h0,0,0);
      if (k >= 12 && k <= 14 && fl[14-k])
                              return vec(0,0,0,1,0,0,1,2'b00,4'h0,0,0);
      return V_ZERO;
   endfunction

   task automatic check(input string tag, input logic [14:0] o,
                        input logic [14:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, o, e);
      end
   endtask

   task automatic check_n(input string tag, input int o, input int e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic rand_flags();
      {flagZ, flagN, flagC} = 3'($urandom);
   endtask

   // Sits in IDLE for one cycle with start high; FETCH follows.
   task automatic start_run(input string tag);
      @(negedge clk);
      start = 1'b1;
      #1;
      check({tag, "/idle_start"}, obs, V_ZERO);
   endtask

   // One full instruction: FETCH (ack after 'delay' wait cycles), DECODE,
   // EXECUTE with 'ex_flags' on the live flag inputs.
   task automatic run_instr(input logic [3:0] op, input logic [IMMW-1:0] imm,
                            input int delay, input logic [2:0] ex_flags,
                            input string tag);
      int req_cnt = 0;
      int lir_cnt = 0;
      for (int i = 0; i <= delay; i++) begin
         @(negedge clk);
         start    = 1'b0;
         imem_ack = (i == delay);
         if (imem_ack) instr = {op, imm};
         rand_flags();
         #1;
         check({tag, "/fetch"}, obs,
               vec(1, imem_ack, imem_ack, 0,0,0,0,2'b00,4'h0,0,0));
         req_cnt += int'(imem_req);
         lir_cnt += int'(loadIR);
      end
      if (delay > 0) begin
         check_n({tag, "/req_cycles"}, req_cnt, delay + 1);
         check_n({tag, "/loadir_pulses"}, lir_cnt, 1);
      end
      @(negedge clk);
      imem_ack = 1'b0;
      rand_flags();
      #1;
      check({tag, "/decode"}, obs, V_ZERO);
      @(negedge clk);
      {flagZ, flagN, flagC} = ex_flags;
      #1;
      check({tag, "/execute"}, obs, exp_exec(op));
      if (int'(op) >= 4 && int'(op) <= 9) {mz, mn, mc} = ex_flags;
   endtask

   // Reset asserted mid-cycle: outputs must clear at once and stay in IDLE.
   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      start    = 1'b0;
      imem_ack = 1'b0;
      {mz, mn, mc} = 3'b000;
      #1;
      check({tag, "/rst_immediate"}, obs, V_ZERO);
      @(negedge clk);
      #1;
      check({tag, "/rst_held"}, obs, V_ZERO);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check({tag, "/idle_after_rst"}, obs, V_ZERO);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", obs, V_ZERO);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("idle_no_start", obs, V_ZERO);

      // LDI 5 with immediate ack
      start_run("ldi5");
      run_instr(OP_LDI_C(), 4'd5, 0, 3'b000, "ldi5");

      // Ack delayed by 3 cycles
      run_instr(4'h2, 4'd1, 3, 3'b000, "ack_delay3");

      // SUB with Z=1, JZ taken although live Z is 0
      run_instr(4'h5, 4'd3, 1, 3'b100, "sub_z1");
      run_instr(4'hC, 4'd9, 0, 3'b011, "jz_taken");
      // SUB with Z=0, JZ not taken although live Z is 1
      run_instr(4'h5, 4'd3, 0, 3'b011, "sub_z0");
      run_instr(4'hC, 4'd9, 0, 3'b100, "jz_not_taken");

      // Ack on the very last permitted cycle wins over the timeout
      run_instr(4'hA, 4'd2, TIMEOUT - 1, 3'b000, "ack_last_cycle");

      // Random instruction stream (HLT excluded)
      for (int n = 0; n < 60; n++) begin
         run_instr(4'($urandom_range(0, 14)), 4'($urandom),
                   int'($urandom_range(0, 4)), 3'($urandom), "random");
      end

      // Reset during EXECUTE of STR: loadReg must drop at once
      run_instr(4'h3, 4'd7, 0, 3'b000, "str");
      #2;
      do_reset("str_exec");

      // Latched flags cleared by reset: conditional jumps not taken
      start_run("post_rst");
      run_instr(4'hC, 4'd1, 0, 3'b111, "jz_after_rst");
      run_instr(4'hD, 4'd1, 0, 3'b111, "jn_after_rst");
      run_instr(4'hE, 4'd1, 0, 3'b111, "jc_after_rst");

      // Fetch timeout: 16 waiting FETCH cycles, then sticky FAULT
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         imem_ack = 1'b0;
         rand_flags();
         #1;
         check("timeout/wait", obs, V_REQ);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start    = 1'b1;
         imem_ack = (i > 0);
         #1;
         check("timeout/fault_sticky", obs, V_FAULT);
      end
      do_reset("fault");

      // HLT: sticky halt, no strobes, cleared only by reset
      start_run("hlt");
      run_instr(4'hF, 4'd0, 1, 3'b111, "hlt");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start    = 1'b1;
         imem_ack = 1'b1;
         rand_flags();
         #1;
         check("hlt/halt_sticky", obs, V_HALT);
      end
      do_reset("halt");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   function automatic logic [3:0] OP_LDI_C();
      return 4'h1;
   endfunction

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ctrl_fsm_hs
